l1_mem_arbiter: RTL and testbench

Two-port arbiter between the L1 instruction cache and the L1 data cache controllers and the single shared downstream memory port (L2 or physical memory). It accepts line-granularity read and write requests from both L1 controllers and grants one at a time, round-robin on conflict. For the granted transaction it latches the command, address and write data, drives the downstream port, and routes the response back to the owner.

---
 rtl/l1_mem_arbiter.sv | 110 +++++++++++
 tb/tb_l1_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter between the L1 I-cache and D-cache controllers and one
// shared line-granularity memory port; one transaction in flight at a time.
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic                    last_grant;    // 0 = I-cache, 1 = D-cache
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LINE_WIDTH-1:0]   cmd_wdata;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // On conflict the port that did not win last time gets the bus.
    assign grant_i = (state == IDLE) && i_req && (!d_req || last_grant);
    assign grant_d = (state == IDLE) && d_req && (!i_req || !last_grant);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_i)      state_next = SERVE_I;
                else if (grant_d) state_next = SERVE_D;
            end
            SERVE_I: begin
                mem_write = cmd_write;
                mem_read  = !cmd_write;
                i_resp    = mem_resp;
                if (mem_resp) state_next = IDLE;
            end
            SERVE_D: begin
                mem_write = cmd_write;
                mem_read  = !cmd_write;
                d_resp    = mem_resp;
                if (mem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_address = cmd_addr;
    assign mem_wdata   = cmd_wdata;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                last_grant <= 1'b0;
                cmd_write  <= i_write;
                cmd_addr   <= i_address;
                cmd_wdata  <= i_wdata;
            end else if (grant_d) begin
                last_grant <= 1'b1;
                cmd_write  <= d_write;
                cmd_addr   <= d_address;
                cmd_wdata  <= d_wdata;
            end
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed self-checking bench for l1_mem_arbiter: inputs change 1 time unit
// after each rising edge, outputs are sampled on the falling edge.
module tb_l1_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [LW-1:0] i_wdata = '0;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic          mem_resp = 1'b0;
    logic [LW-1:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; stimulus for the new cycle follows.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Packed view of strobes and responses: {mem_read, mem_write, i_resp, d_resp}.
    function automatic logic [3:0] ctl();
        return {mem_read, mem_write, i_resp, d_resp};
    endfunction

    task automatic do_reset();
        tick();
        reset = 1'b1;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_resp = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=0000", ctl());
        end
        total++;
        if (mem_address !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL reset_bus addr=%h wdata=%h exp=0", mem_address, mem_wdata);
        end
        tick();
        reset = 1'b0;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL after_reset_ctl got=%b exp=0000", ctl());
        end
    endtask

    task automatic test_single_read();
        tick();                                   // cycle 0
        d_read = 1; d_address = 16'h1230;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL sr_c0 got=%b exp=0000", ctl());
        end
        for (int c = 1; c <= 3; c++) begin        // cycles 1..3 waiting
            tick();
            sample();
            total++;
            if (ctl() !== 4'b1000 || mem_address !== 16'h1230) begin
                bad++; $display("FAIL sr_wait c=%0d ctl=%b addr=%h exp=1000/1230", c, ctl(), mem_address);
            end
        end
        tick();                                   // cycle 4
        mem_resp = 1; mem_rdata = {16{8'hA5}};
        sample();
        total++;
        if (ctl() !== 4'b1001 || d_rdata !== {16{8'hA5}}) begin
            bad++; $display("FAIL sr_resp ctl=%b rdata=%h exp=1001/a5..", ctl(), d_rdata);
        end
        tick();                                   // cycle 5
        mem_resp = 0; d_read = 0;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL sr_c5 got=%b exp=0000", ctl());
        end
    endtask

    task automatic test_conflict_after_reset();
        do_reset();
        tick();                                   // cycle 0: both request
        i_read = 1; i_address = 16'h0040;
        d_write = 1; d_address = 16'h0080; d_wdata = {4{32'hDEADBEEF}};
        sample();
        tick();                                   // cycle 1: D write granted
        i_address = 16'h0044;                     // change before grant is taken
        sample();
        total++;
        if (ctl() !== 4'b0100 || mem_address !== 16'h0080 || mem_wdata !== {4{32'hDEADBEEF}}) begin
            bad++; $display("FAIL cf_dwrite ctl=%b addr=%h wdata=%h exp=0100/0080/deadbeef..", ctl(), mem_address, mem_wdata);
        end
        tick();                                   // cycle 2: completion
        mem_resp = 1;
        sample();
        total++;
        if (ctl() !== 4'b0101) begin
            bad++; $display("FAIL cf_dresp got=%b exp=0101", ctl());
        end
        tick();                                   // cycle 3: mandatory idle
        mem_resp = 0; d_write = 0;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL cf_idle got=%b exp=0000", ctl());
        end
        tick();                                   // cycle 4: I read, completes
        mem_resp = 1; mem_rdata = {8{16'h1357}};
        sample();
        total++;
        if (ctl() !== 4'b1010 || mem_address !== 16'h0044 || i_rdata !== {8{16'h1357}}) begin
            bad++; $display("FAIL cf_iread ctl=%b addr=%h rdata=%h exp=1010/0044/1357..", ctl(), mem_address, i_rdata);
        end
        tick();
        mem_resp = 0; i_read = 0;
        sample();
    endtask

    // last_grant is I after the previous test, so D must win first.
    task automatic test_fairness();
        logic [AW-1:0] exp_addr;
        logic [3:0]    exp_ctl;
        tick();
        i_read = 1; i_address = 16'h0A00;
        d_read = 1; d_address = 16'h0D00;
        sample();
        for (int k = 0; k < 6; k++) begin
            exp_addr = (k % 2 == 0) ? 16'h0D00 : 16'h0A00;
            exp_ctl  = (k % 2 == 0) ? 4'b1001 : 4'b1010;
            tick();
            mem_resp = 1;
            sample();
            total++;
            if (ctl() !== exp_ctl || mem_address !== exp_addr) begin
                bad++; $display("FAIL fair k=%0d ctl=%b addr=%h exp=%b/%h", k, ctl(), mem_address, exp_ctl, exp_addr);
            end
            tick();
            mem_resp = 0;
            if (k == 5) begin i_read = 0; d_read = 0; end
            sample();
            total++;
            if (ctl() !== 4'b0000) begin
                bad++; $display("FAIL fair_idle k=%0d got=%b exp=0000", k, ctl());
            end
        end
    endtask

    // last_grant is I again, so D write-back wins; I then sneaks in before the refill.
    task automatic test_back_to_back();
        tick();                                   // cycle 0
        d_write = 1; d_address = 16'h4000; d_wdata = {2{64'h0123456789ABCDEF}};
        i_read = 1; i_address = 16'h8880;
        sample();
        tick();                                   // cycle 1
        mem_resp = 1;
        sample();
        total++;
        if (ctl() !== 4'b0101 || mem_address !== 16'h4000) begin
            bad++; $display("FAIL b2b_wb ctl=%b addr=%h exp=0101/4000", ctl(), mem_address);
        end
        tick();                                   // cycle 2: idle, refill requested
        mem_resp = 0; d_write = 0; d_read = 1; d_address = 16'h2000;
        sample();
        tick();                                   // cycle 3
        mem_resp = 1;
        sample();
        total++;
        if (ctl() !== 4'b1010 || mem_address !== 16'h8880) begin
            bad++; $display("FAIL b2b_i ctl=%b addr=%h exp=1010/8880", ctl(), mem_address);
        end
        tick();                                   // cycle 4: idle
        mem_resp = 0; i_read = 0;
        sample();
        tick();                                   // cycle 5: refill, disturb input
        d_address = 16'hFFFF;
        sample();
        total++;
        if (ctl() !== 4'b1000 || mem_address !== 16'h2000) begin
            bad++; $display("FAIL b2b_refill ctl=%b addr=%h exp=1000/2000", ctl(), mem_address);
        end
        tick();                                   // cycle 6
        mem_resp = 1;
        sample();
        total++;
        if (ctl() !== 4'b1001 || mem_address !== 16'h2000) begin
            bad++; $display("FAIL b2b_stable ctl=%b addr=%h exp=1001/2000", ctl(), mem_address);
        end
        tick();
        mem_resp = 0; d_read = 0;
        sample();
    endtask

    task automatic test_reset_mid();
        tick();                                   // cycle 0
        i_read = 1; i_address = 16'h0120;
        sample();
        tick();                                   // cycle 1
        sample();
        total++;
        if (ctl() !== 4'b1000) begin
            bad++; $display("FAIL rm_c1 got=%b exp=1000", ctl());
        end
        tick();                                   // cycle 2: reset asserted
        reset = 1; i_read = 0;
        sample();
        total++;
        if (ctl() !== 4'b1000) begin
            bad++; $display("FAIL rm_c2 got=%b exp=1000", ctl());
        end
        tick();                                   // cycle 3
        reset = 0;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL rm_c3 got=%b exp=0000", ctl());
        end
        tick();                                   // cycle 4: late response in IDLE
        mem_resp = 1;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL rm_late got=%b exp=0000", ctl());
        end
        tick();
        mem_resp = 0;
        sample();
        total++;
        if (ctl() !== 4'b0000) begin
            bad++; $display("FAIL rm_after got=%b exp=0000", ctl());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_conflict_after_reset();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule
